// File: rtl/dm_access_seq.sv
// M-stage data-memory access sequencer: turns lw/sw into a held memory request,
// stalls the pipeline until ack or timeout, and registers load data.
module dm_access_seq #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] IR_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    input  logic        flush_M,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall,
    output logic [31:0] rdata_M,
    output logic        addr_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    localparam logic [5:0] OpLw = 6'b100011;
    localparam logic [5:0] OpSw = 6'b101011;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:2]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              bus_err_q, bus_err_d;
    logic              stall_c, addr_err_c, req_c;

    logic [5:0] op;
    logic       is_lw, is_sw, is_mem, aligned;
    logic       unused_ir;

    assign op        = IR_M[31:26];
    assign unused_ir = ^IR_M[25:0];
    assign is_lw     = (op == OpLw);
    assign is_sw     = (op == OpSw);
    assign is_mem    = (is_lw | is_sw) & ~flush_M;
    assign aligned   = (addr_M[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        rdata_d    = rdata_q;
        bus_err_d  = 1'b0;
        stall_c    = 1'b0;
        addr_err_c = 1'b0;
        req_c      = 1'b0;
        case (state_q)
            StIdle: begin
                if (is_mem && aligned) begin
                    stall_c = 1'b1;
                    addr_d  = addr_M[31:2];
                    wdata_d = wdata_M;
                    we_d    = is_sw;
                    cnt_d   = '0;
                    state_d = StBusy;
                end else if (is_mem) begin
                    addr_err_c = 1'b1;
                end
            end
            StBusy: begin
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (mem_ack) begin
                    if (!we_q) rdata_d = mem_rdata;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        bus_err_d = 1'b1;
                        if (!we_q) rdata_d = 32'h0;
                        state_d = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Combinational outputs driven from IR_M are gated so reset forces them low at once.
    assign stall     = reset_n & stall_c;
    assign addr_err  = reset_n & addr_err_c;
    assign mem_req   = req_c;
    assign mem_we    = req_c & we_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign rdata_M   = rdata_q;
    assign bus_err   = bus_err_q;

endmodule
